// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants, hex-to-segment table and leading-zero helper for seg7_scan_driver
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    // Segment pattern that lights nothing, in active-high gfedcba form
    localparam logic [6:0] SEG_BLANK_AH = 7'h00;

    // Active-high gfedcba patterns for hex digits 0..F
    localparam logic [6:0] HEX_SEG_AH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Digit k is a leading zero when it is not digit 0 and it and every higher nibble are zero
    function automatic logic lz_blank(input logic [15:0] value, input int k);
        return (k > 0) && ((value >> (4 * k)) == 16'h0);
    endfunction

endpackage

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// hex_to_seg7: combinational 4-bit hex to 7-segment {g,f,e,d,c,b,a} decoder with selectable polarity
module hex_to_seg7
    import seg7_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    logic [6:0] seg_ah;

    assign seg_ah = HEX_SEG_AH[hex];
    assign seg    = SEG_ACTIVE_LOW ? ~seg_ah : seg_ah;

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit multiplexed 7-segment driver with tear-free frame commit, leading-zero blanking
// and an anode-off guard interval after every digit switch. Optional decimal point: SEG7_DECIMAL_POINT_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int GUARD_CYCLES   = 16,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  digit_sel,
    input  logic [15:0] value,
    input  logic        value_valid,
    output logic        value_ready,
    input  logic        blank_lz,
`ifdef SEG7_DECIMAL_POINT_EN
    input  logic [3:0]  dp_mask,
    output logic        dp,
`endif
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        frame_done
);

    localparam int GW = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
    localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES);
    localparam logic [3:0] AN_OFF = AN_ACTIVE_LOW ? 4'hF : 4'h0;
    localparam logic [6:0] SEG_BLANK = SEG_ACTIVE_LOW ? ~SEG_BLANK_AH : SEG_BLANK_AH;

    logic          pending;
    logic [15:0]   pend_reg;
    logic [15:0]   disp_reg;
    logic [15:0]   disp_d;
    logic [1:0]    sel_q;
    logic [GW-1:0] guard_cnt;
    logic [GW-1:0] guard_d;
    logic          boundary;
    logic          accept;
    logic          commit;
    logic [3:0]    nibble;
    logic [3:0]    an_d;
    logic [6:0]    dec_seg;
    logic [6:0]    seg_d;

    assign value_ready = !pending;
    assign accept      = value_valid && !pending;
    assign boundary    = (sel_q == 2'd3) && (digit_sel == 2'd0);
    assign commit      = boundary && pending;

    hex_to_seg7 #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec (
        .hex (nibble),
        .seg (dec_seg)
    );

    // Next-state view of display, guard and outputs; outputs are registered from these so they never glitch
    always_comb begin
        disp_d  = commit ? pend_reg : disp_reg;
        guard_d = (digit_sel != sel_q) ? GUARD_LOAD : (guard_cnt != '0) ? guard_cnt - GW'(1) : '0;
        nibble  = 4'(disp_d >> {digit_sel, 2'b00});
        an_d    = (guard_d != '0) ? AN_OFF : AN_ACTIVE_LOW ? ~(4'b0001 << digit_sel) : (4'b0001 << digit_sel);
        seg_d   = (blank_lz && lz_blank(disp_d, int'(digit_sel))) ? SEG_BLANK : dec_seg;
    end

    // Handshake capture into the pending slot and commit to the display at frame boundaries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= 1'b0;
            pend_reg <= '0;
            disp_reg <= '0;
        end else begin
            pending  <= commit ? 1'b0 : accept ? 1'b1 : pending;
            if (accept) pend_reg <= value;
            disp_reg <= disp_d;
        end
    end

    // Scan tracking, guard countdown and registered display outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q      <= 2'd0;
            guard_cnt  <= GUARD_LOAD;
            an         <= AN_OFF;
            seg        <= SEG_BLANK;
            frame_done <= 1'b0;
        end else begin
            sel_q      <= digit_sel;
            guard_cnt  <= guard_d;
            an         <= an_d;
            seg        <= seg_d;
            frame_done <= boundary;
        end
    end

`ifdef SEG7_DECIMAL_POINT_EN
    logic [3:0] pend_dp;
    logic [3:0] disp_dp;
    logic [3:0] disp_dp_d;
    logic       dp_lit;

    // Decimal point follows the committed mask and is dark during the guard; blanking never touches it
    always_comb begin
        disp_dp_d = commit ? pend_dp : disp_dp;
        dp_lit    = (guard_d == '0) && disp_dp_d[digit_sel];
    end

    // Decimal-point mask travels through pending/display alongside the value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_dp <= '0;
            disp_dp <= '0;
            dp      <= SEG_ACTIVE_LOW;
        end else begin
            if (accept) pend_dp <= dp_mask;
            disp_dp <= disp_dp_d;
            dp      <= SEG_ACTIVE_LOW ? !dp_lit : dp_lit;
        end
    end
`endif

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed and randomized checks of seg7_scan_driver against a history-based reference model
`timescale 1ns/1ps
module tb_seg7_scan_driver;

    localparam int G = 16;
    localparam logic [6:0] HEX_AH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  digit_sel = 2'd0;
    logic [15:0] value = 16'h0;
    logic        value_valid = 1'b0;
    logic        blank_lz = 1'b0;
    logic        value_ready;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame_done;
`ifdef SEG7_DECIMAL_POINT_EN
    logic [3:0]  dp_mask = 4'h0;
    logic        dp;
`endif

    int vectors = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg7_scan_driver dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .digit_sel   (digit_sel),
        .value       (value),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .blank_lz    (blank_lz),
`ifdef SEG7_DECIMAL_POINT_EN
        .dp_mask     (dp_mask),
        .dp          (dp),
`endif
        .an          (an),
        .seg         (seg),
        .frame_done  (frame_done)
    );

    // Reference model: digit_sel seen at every edge since reset, plus transaction-level display state
    int          hist[$];
    bit          m_pending;
    logic [15:0] m_pend;
    logic [15:0] m_disp;
    bit          m_blank;
    logic [3:0]  m_pend_dp;
    logic [3:0]  m_disp_dp;

    function automatic void model_reset();
        hist.delete();
        m_pending = 0;
        m_pend    = 16'h0;
        m_disp    = 16'h0;
        m_blank   = 0;
        m_pend_dp = 4'h0;
        m_disp_dp = 4'h0;
    endfunction

    // A digit is lit only if no switch happened in the last G edges (reset counts as a switch just before edge 0)
    function automatic logic [3:0] exp_an();
        int t = hist.size() - 1;
        if (t < 0 || t <= G - 2) return 4'hF;
        for (int j = t - G + 1; j <= t; j++) begin
            if (j >= 0 && hist[j] != ((j == 0) ? 0 : hist[j-1])) return 4'hF;
        end
        return ~(4'b0001 << hist[t]);
    endfunction

    function automatic logic [6:0] exp_seg();
        int t = hist.size() - 1;
        int sel;
        logic [15:0] rest;
        if (t < 0) return 7'h7F;
        sel  = hist[t];
        rest = m_disp >> (4 * sel);
        if (m_blank && sel > 0 && rest == 16'h0) return 7'h7F;
        return ~HEX_AH[rest[3:0]];
    endfunction

    function automatic logic exp_fd();
        int t = hist.size() - 1;
        if (t < 0) return 1'b0;
        return ((t == 0) ? 0 : hist[t-1]) == 3 && hist[t] == 0;
    endfunction

    function automatic logic exp_dp();
        int t = hist.size() - 1;
        if (exp_an() == 4'hF) return 1'b1;
        return !m_disp_dp[hist[t]];
    endfunction

    // Advance one clock edge, updating the model with the inputs the DUT sampled; returns 1ns after the edge
    task automatic tick();
        int prev;
        @(posedge clk);
        prev = (hist.size() == 0) ? 0 : hist[$];
        if (prev == 3 && digit_sel == 2'd0 && m_pending) begin
            m_disp    = m_pend;
            m_disp_dp = m_pend_dp;
            m_pending = 0;
        end else if (value_valid && !m_pending) begin
            m_pend    = value;
            m_pending = 1;
`ifdef SEG7_DECIMAL_POINT_EN
            m_pend_dp = dp_mask;
`endif
        end
        m_blank = blank_lz;
        hist.push_back(int'(digit_sel));
        #1;
    endtask

    // Hand a value over and drive a 3->0 sweep so it is committed; leaves digit_sel at 0
    task automatic load_commit(input logic [15:0] v);
        value = v;
        value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
        digit_sel = 2'd3;
        tick();
        digit_sel = 2'd0;
        tick();
    endtask

    task automatic test_reset();
        #23;
        vectors++; if (an !== 4'hF) $display("FAIL reset_an: got %h want f", an);
        vectors++; if (seg !== 7'h7F) $display("FAIL reset_seg: got %h want 7f", seg);
        vectors++; if (frame_done !== 1'b0) $display("FAIL reset_fd: got %b want 0", frame_done);
        errors += (an !== 4'hF) + (seg !== 7'h7F) + (frame_done !== 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        vectors++;
        if (value_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", value_ready); end
    endtask

    task automatic test_load();
        value = 16'h1234;
        value_valid = 1'b1;
        digit_sel = 2'd0;
        vectors++;
        if (value_ready !== 1'b1) begin errors++; $display("FAIL load_ready: got %b want 1", value_ready); end
        tick();
        value_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            digit_sel = 2'(k);
            repeat (3) tick();
        end
        digit_sel = 2'd0;
        tick();
        vectors++;
        if (frame_done !== 1'b1) begin errors++; $display("FAIL load_fd: got %b want 1", frame_done); end
        for (int i = 2; i <= 16; i++) begin
            tick();
            vectors++;
            if (an !== 4'hF) begin errors++; $display("FAIL load_guard_an +%0d: got %h want f", i, an); end
        end
        tick();
        vectors++;
        if (an !== 4'b1110) begin errors++; $display("FAIL load_an: got %b want 1110", an); end
        vectors++;
        if (seg !== 7'h19) begin errors++; $display("FAIL load_seg: got %h want 19", seg); end
        vectors++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL load_fd_drop: got %b want 0", frame_done); end
    endtask

    task automatic test_guard();
        digit_sel = 2'd1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            vectors++;
            if (an !== 4'hF) begin errors++; $display("FAIL guard_an N+%0d: got %h want f", i, an); end
        end
        tick();
        vectors++;
        if (an !== 4'b1101) begin errors++; $display("FAIL guard_an N+17: got %b want 1101", an); end
        digit_sel = 2'd2;
        for (int i = 1; i <= 5; i++) begin
            tick();
            vectors++;
            if (an !== 4'hF) begin errors++; $display("FAIL guard2_an N+%0d: got %h want f", i, an); end
        end
        digit_sel = 2'd3;
        for (int i = 6; i <= 21; i++) begin
            tick();
            vectors++;
            if (an !== 4'hF) begin errors++; $display("FAIL guard2_an N+%0d: got %h want f", i, an); end
        end
        tick();
        vectors++;
        if (an !== 4'b0111) begin errors++; $display("FAIL guard2_an N+22: got %b want 0111", an); end
    endtask

    task automatic test_backpressure();
        value = 16'hAAAA;
        value_valid = 1'b1;
        vectors++;
        if (value_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_first: got %b want 1", value_ready); end
        tick();
        value = 16'h5555;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (value_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_held %0d: got %b want 0", i, value_ready); end
            tick();
            vectors++;
            if (seg !== 7'h79) begin errors++; $display("FAIL bp_seg_held %0d: got %h want 79", i, seg); end
        end
        digit_sel = 2'd0;
        tick();
        vectors++;
        if (value_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after: got %b want 1", value_ready); end
        vectors++;
        if (frame_done !== 1'b1) begin errors++; $display("FAIL bp_fd: got %b want 1", frame_done); end
        tick();
        value_valid = 1'b0;
        vectors++;
        if (value_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_second: got %b want 0", value_ready); end
        repeat (17) tick();
        vectors++;
        if (seg !== 7'h08 || an !== 4'b1110) begin
            errors++; $display("FAIL bp_show_a: got seg %h an %b want seg 08 an 1110", seg, an);
        end
        digit_sel = 2'd3;
        tick();
        digit_sel = 2'd0;
        tick();
        repeat (17) tick();
        vectors++;
        if (seg !== 7'h12 || an !== 4'b1110) begin
            errors++; $display("FAIL bp_show_5: got seg %h an %b want seg 12 an 1110", seg, an);
        end
    endtask

    task automatic test_leading_zero();
        logic [6:0] want;
        blank_lz = 1'b1;
        load_commit(16'h0005);
        for (int k = 3; k >= 0; k--) begin
            digit_sel = 2'(k);
            repeat (17) tick();
            want = (k > 0) ? 7'h7F : 7'h12;
            vectors++;
            if (seg !== want) begin errors++; $display("FAIL lz_0005 digit%0d: got %h want %h", k, seg, want); end
        end
        load_commit(16'h0000);
        repeat (17) tick();
        vectors++;
        if (seg !== 7'h40) begin errors++; $display("FAIL lz_0000 digit0: got %h want 40", seg); end
        blank_lz = 1'b0;
        digit_sel = 2'd3;
        repeat (17) tick();
        vectors++;
        if (seg !== 7'h40) begin errors++; $display("FAIL lz_off digit3: got %h want 40", seg); end
        digit_sel = 2'd0;
        tick();
    endtask

`ifdef SEG7_DECIMAL_POINT_EN
    task automatic test_dp();
        dp_mask = 4'b0010;
        load_commit(16'h4321);
        dp_mask = 4'b0000;
        digit_sel = 2'd1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            vectors++;
            if (dp !== 1'b1) begin errors++; $display("FAIL dp_guard N+%0d: got %b want 1", i, dp); end
        end
        tick();
        vectors++;
        if (dp !== 1'b0 || an !== 4'b1101) begin
            errors++; $display("FAIL dp_lit: got dp %b an %b want dp 0 an 1101", dp, an);
        end
        digit_sel = 2'd2;
        repeat (17) tick();
        vectors++;
        if (dp !== 1'b1) begin errors++; $display("FAIL dp_other: got %b want 1", dp); end
    endtask
`endif

    task automatic test_random();
        logic [15:0] masks [5] = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 24) == 0)
                digit_sel = ($urandom_range(0, 9) < 6) ? digit_sel + 2'd1 : 2'($urandom_range(0, 3));
            value_valid = ($urandom_range(0, 3) == 0);
            value = 16'($urandom) & masks[$urandom_range(0, 4)];
            if ($urandom_range(0, 99) == 0) blank_lz = ~blank_lz;
`ifdef SEG7_DECIMAL_POINT_EN
            dp_mask = 4'($urandom);
`endif
            vectors++;
            if (value_ready !== !m_pending) begin
                errors++; $display("FAIL rand_ready cyc %0d: got %b want %b", i, value_ready, !m_pending);
            end
            tick();
            vectors++;
            if (an !== exp_an()) begin errors++; $display("FAIL rand_an cyc %0d: got %b want %b", i, an, exp_an()); end
            vectors++;
            if (seg !== exp_seg()) begin errors++; $display("FAIL rand_seg cyc %0d: got %h want %h", i, seg, exp_seg()); end
            vectors++;
            if (frame_done !== exp_fd()) begin
                errors++; $display("FAIL rand_fd cyc %0d: got %b want %b", i, frame_done, exp_fd());
            end
`ifdef SEG7_DECIMAL_POINT_EN
            vectors++;
            if (dp !== exp_dp()) begin errors++; $display("FAIL rand_dp cyc %0d: got %b want %b", i, dp, exp_dp()); end
`endif
        end
        value_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        blank_lz = 1'b0;
        digit_sel = 2'd1;
        value = 16'hBEEF;
        value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
        repeat (20) tick();
        vectors++;
        if (an !== 4'b1101) begin errors++; $display("FAIL mid_pre_an: got %b want 1101", an); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (an !== 4'hF) begin errors++; $display("FAIL mid_an: got %h want f", an); end
        vectors++; if (seg !== 7'h7F) begin errors++; $display("FAIL mid_seg: got %h want 7f", seg); end
        vectors++; if (frame_done !== 1'b0) begin errors++; $display("FAIL mid_fd: got %b want 0", frame_done); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (value_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", value_ready); end
        for (int i = 0; i < 20; i++) begin
            tick();
            vectors++;
            if (an !== exp_an()) begin errors++; $display("FAIL mid_an_post %0d: got %b want %b", i, an, exp_an()); end
        end
        vectors++;
        if (seg !== 7'h40 || an !== 4'b1101) begin
            errors++; $display("FAIL mid_discard: got seg %h an %b want seg 40 an 1101", seg, an);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_load();
        test_guard();
        test_backpressure();
        test_leading_zero();
`ifdef SEG7_DECIMAL_POINT_EN
        test_dp();
`endif
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
